// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: operation modes, FSM state
// encodings and the elaboration-time helpers that size the step counter.
package shifter_pkg;

    // Shift operation selected per request
    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    // Controller states; the unused encoding 2'b11 falls back to IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Number of SHIFT cycles needed to walk every shift-amount bit
    function automatic int calc_lat(input int shamt_w, input int bits_per_cycle);
        return (shamt_w + bits_per_cycle - 1) / bits_per_cycle;
    endfunction

    // Step counter width; a single-step shifter still keeps a 1-bit counter
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One iteration of the shifter: applies the power-of-two shifts selected by
// the current slice of the shift amount, lowest bit first.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int CNT_W          = 3
) (
    input  logic [WIDTH-1:0]          i_acc,
    input  logic [BITS_PER_CYCLE-1:0] i_amt_bits,
    input  logic [CNT_W-1:0]          i_cnt,
    input  mode_e                     i_md,
    input  logic                      i_sign,
    output logic [WIDTH-1:0]          o_acc
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_fill;
    int               w_k;
    int               w_s;

    // Compose this cycle's shifts in ascending bit order; bit k of the amount
    // is worth 2^k, and slice bits past the top of the amount are ignored
    always_comb begin
        w_acc  = i_acc;
        w_fill = '0;
        w_k    = 0;
        w_s    = 0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            w_k = int'(i_cnt) * BITS_PER_CYCLE + j;
            if ((w_k < SHAMT_W) && i_amt_bits[j]) begin
                w_s = 1 << w_k;
                case (i_md)
                    MODE_SLL: w_acc = w_acc << w_s;
                    MODE_SRL: w_acc = w_acc >> w_s;
                    MODE_SRA: begin
                        // Sign comes from the captured operand, not the
                        // partially shifted accumulator
                        w_fill = ~({WIDTH{1'b1}} >> w_s) & {WIDTH{i_sign}};
                        w_acc  = (w_acc >> w_s) | w_fill;
                    end
                    MODE_ROL: w_acc = (w_acc << w_s) | (w_acc >> (WIDTH - w_s));
                    default:  w_acc = w_acc;
                endcase
            end
        end
    end

    assign o_acc = w_acc;

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROL) with valid/ready on both
// sides. Latency is fixed at LAT shift cycles regardless of the amount.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_out
);

    localparam int SHAMT_W   = $clog2(WIDTH);
    localparam int LAT       = calc_lat(SHAMT_W, BITS_PER_CYCLE);
    localparam int CNT_W     = cnt_width(LAT);
    localparam int AMT_PAD_W = LAT * BITS_PER_CYCLE;

    state_e               r_state;
    state_e               w_next_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_dout;
    logic [SHAMT_W-1:0]   r_amt;
    mode_e                r_md;
    logic                 r_sign;
    logic [CNT_W-1:0]     r_cnt;

    logic                      w_accept;
    logic                      w_last;
    logic [AMT_PAD_W-1:0]      w_amt_pad;
    logic [BITS_PER_CYCLE-1:0] w_amt_bits;
    logic [WIDTH-1:0]          w_step;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == CNT_W'(LAT - 1));
    // Zero-pad the amount so the last slice is full width even when
    // BITS_PER_CYCLE does not divide SHAMT_W
    assign w_amt_pad = AMT_PAD_W'(r_amt);

    // Pick the slice of the shift amount handled in the current step
    always_comb begin
        w_amt_bits = '0;
        for (int c = 0; c < LAT; c++) begin
            if (r_cnt == CNT_W'(c)) begin
                w_amt_bits = w_amt_pad[c*BITS_PER_CYCLE +: BITS_PER_CYCLE];
            end
        end
    end

    shift_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CNT_W          (CNT_W)
    ) u_step (
        .i_acc      (r_acc),
        .i_amt_bits (w_amt_bits),
        .i_cnt      (r_cnt),
        .i_md       (r_md),
        .i_sign     (r_sign),
        .o_acc      (w_step)
    );

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unused encodings recover to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign data_out = r_dout;

    // Operand capture on accept, one shift step per SHIFT cycle; the result
    // register only updates on the final step so it holds between operations
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_dout <= '0;
            r_amt  <= '0;
            r_md   <= MODE_SLL;
            r_sign <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_acc  <= data_in;
            r_amt  <= shamt;
            r_md   <= mode_e'(mode);
            r_sign <= data_in[WIDTH-1];
            r_cnt  <= '0;
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_step;
            if (w_last) begin
                r_dout <= w_step;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: a BITS_PER_CYCLE=1 instance (LAT=5)
// and a BITS_PER_CYCLE=5 instance (LAT=1), scoreboard-queue based.
module tb_iter_shifter;

    localparam int LAT1 = 5;
    localparam int LAT5 = 1;

    localparam logic [31:0] VD [9] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                                       32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF,
                                       32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    localparam logic [4:0]  VS [9] = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0};
    localparam logic [1:0]  VM [9] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    localparam logic [31:0] VE [9] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                                       32'h0000_0003, 32'h3456_7812, 32'hDEAD_BEEF,
                                       32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    logic        clock = 1'b0;
    logic        reset_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] data_in, data_out;
    logic [4:0]  shamt;
    logic [1:0]  mode;

    logic        in_valid5, in_ready5, out_valid5, out_ready5;
    logic [31:0] data_in5, data_out5;
    logic [4:0]  shamt5;
    logic [1:0]  mode5;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q  [$];
    logic [31:0] exp5_q [$];

    always #5 clock = ~clock;

    iter_shifter #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    iter_shifter #(.WIDTH(32), .BITS_PER_CYCLE(5)) dut5 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .data_in   (data_in5),
        .shamt     (shamt5),
        .mode      (mode5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .data_out  (data_out5)
    );

    // Single-step reference shift
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
        endcase
    endfunction

    // Drive one request into the LAT=5 instance and queue its expected result
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                        input logic [31:0] e, output bit ok);
        int guard = 0;
        @(negedge clock);
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        ok = (in_ready === 1'b1);
        if (ok) begin
            in_valid = 1'b1;
            data_in  = d;
            shamt    = s;
            mode     = m;
            @(posedge clock);
            exp_q.push_back(e);
            @(negedge clock);
            in_valid = 1'b0;
            data_in  = $urandom;
            shamt    = 5'($urandom);
            mode     = 2'($urandom);
        end
    endtask

    // Count falling edges from the accept until out_valid (bounded)
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0; data_in  = '0; shamt  = '0; mode  = '0; out_ready  = 1'b1;
        in_valid5 = 1'b0; data_in5 = '0; shamt5 = '0; mode5 = '0; out_ready5 = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({in_ready, out_valid, data_out} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state: rdy/vld/data=%b/%b/%h want 1/0/00000000", in_ready, out_valid, data_out);
        end
        n_vec++;
        if ({in_ready5, out_valid5, data_out5} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state5: rdy/vld/data=%b/%b/%h want 1/0/00000000", in_ready5, out_valid5, data_out5);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL after_reset: rdy/vld=%b/%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        bit ok;
        int lat;
        logic [31:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(VD[i], VS[i], VM[i], VE[i], ok);
            wait_out(lat);
            n_vec++;
            if (!ok || lat != LAT1) begin
                n_err++;
                $display("FAIL directed_lat[%0d]: latency %0d want %0d", i, lat, LAT1);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            n_vec++;
            if (data_out !== e) begin
                n_err++;
                $display("FAIL directed_data[%0d]: got %h want %h", i, data_out, e);
            end
            @(negedge clock);
            n_vec++;
            if ({out_valid, in_ready, data_out} !== {1'b0, 1'b1, e}) begin
                n_err++;
                $display("FAIL directed_release[%0d]: vld/rdy/data=%b/%b/%h want 0/1/%h", i, out_valid, in_ready, data_out, e);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        logic [31:0] d, e;
        logic [4:0]  s;
        logic [1:0]  m;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            if (i < 4) d[31] = 1'b1;
            s = 5'($urandom);
            m = 2'(i);
            send(d, s, m, ref_shift(d, s, m), ok);
            wait_out(lat);
            n_vec++;
            if (!ok || lat != LAT1) begin
                n_err++;
                $display("FAIL random_lat[%0d]: latency %0d want %0d", i, lat, LAT1);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            n_vec++;
            if (data_out !== e) begin
                n_err++;
                $display("FAIL random_data[%0d] d=%h s=%0d m=%0d: got %h want %h", i, d, s, m, data_out, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [31:0] e;
        out_ready = 1'b0;
        send(32'hA5A5_0F0F, 5'd3, 2'b10, 32'hF4B4_A1E1, ok);
        wait_out(lat);
        n_vec++;
        if (!ok || lat != LAT1) begin
            n_err++;
            $display("FAIL bp_lat: latency %0d want %0d", lat, LAT1);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            data_in  = $urandom;
            shamt    = 5'($urandom);
            mode     = 2'($urandom);
            @(posedge clock);
            @(negedge clock);
            n_vec++;
            if ({out_valid, in_ready, data_out} !== {1'b1, 1'b0, e}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: vld/rdy/data=%b/%b/%h want 1/0/%h", c, out_valid, in_ready, data_out, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_vec++;
        if ({out_valid, in_ready, data_out} !== {1'b0, 1'b1, e}) begin
            n_err++;
            $display("FAIL bp_release: vld/rdy/data=%b/%b/%h want 0/1/%h", out_valid, in_ready, data_out, e);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            n_vec++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL bp_no_ghost[%0d]: vld/rdy=%b/%b want 0/1", c, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [3];
        int n_acc = 0;
        int guard = 0;
        logic [31:0] d, e;
        logic [4:0]  s;
        logic [1:0]  m;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                n_vec++;
                if (data_out !== e) begin
                    n_err++;
                    $display("FAIL b2b_data@%0d: got %h want %h", cyc, data_out, e);
                end
            end
            in_valid = 1'b1;
            d = $urandom;
            s = 5'($urandom);
            m = 2'($urandom);
            data_in = d;
            shamt   = s;
            mode    = m;
            if (in_ready === 1'b1) begin
                if (n_acc < 3) acc_cyc[n_acc] = cyc;
                n_acc++;
                exp_q.push_back(ref_shift(d, s, m));
            end
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0 && guard < 40) begin
            @(negedge clock);
            guard++;
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++;
                if (data_out !== e) begin
                    n_err++;
                    $display("FAIL b2b_drain: got %h want %h", data_out, e);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0 || n_acc < 3) begin
            n_err++;
            $display("FAIL b2b_complete: pending %0d accepts %0d want 0 and >=3", exp_q.size(), n_acc);
            exp_q.delete();
        end else begin
            n_vec++;
            if ((acc_cyc[1] - acc_cyc[0] != LAT1 + 2) || (acc_cyc[2] - acc_cyc[1] != LAT1 + 2)) begin
                n_err++;
                $display("FAIL b2b_interval: %0d,%0d want %0d", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], LAT1 + 2);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_mid_reset();
        bit ok;
        int lat;
        logic [31:0] d, e;
        out_ready = 1'b1;
        send(32'h0F0F_1234, 5'd7, 2'b11, ref_shift(32'h0F0F_1234, 5'd7, 2'b11), ok);
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, in_ready, data_out} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_shift: vld/rdy/data=%b/%b/%h want 0/1/00000000", out_valid, in_ready, data_out);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        d = 32'h00F0_00F1;
        send(d, 5'd5, 2'b01, 32'h0007_8007, ok);
        wait_out(lat);
        n_vec++;
        if (!ok || lat != LAT1) begin
            n_err++;
            $display("FAIL post_reset_lat: latency %0d want %0d", lat, LAT1);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++;
        if (data_out !== e) begin
            n_err++;
            $display("FAIL post_reset_data: got %h want %h", data_out, e);
        end
        @(negedge clock);
        out_ready = 1'b0;
        send(32'h8765_4321, 5'd16, 2'b00, 32'h4321_0000, ok);
        wait_out(lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_vec++;
        if ({out_valid, data_out} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL pre_done_reset: vld/data=%b/%h want 1/%h", out_valid, data_out, e);
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, in_ready, data_out} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_done: vld/rdy/data=%b/%b/%h want 0/1/00000000", out_valid, in_ready, data_out);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_lat1();
        int lat;
        logic [31:0] d, e;
        logic [4:0]  s;
        logic [1:0]  m;
        out_ready5 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 9) begin
                d = VD[i]; s = VS[i]; m = VM[i];
            end else begin
                d = $urandom; s = 5'($urandom); m = 2'(i);
            end
            @(negedge clock);
            n_vec++;
            if (in_ready5 !== 1'b1) begin
                n_err++;
                $display("FAIL lat1_ready[%0d]: got %b want 1", i, in_ready5);
            end
            in_valid5 = 1'b1;
            data_in5  = d;
            shamt5    = s;
            mode5     = m;
            @(posedge clock);
            exp5_q.push_back((i < 9) ? VE[i] : ref_shift(d, s, m));
            @(negedge clock);
            in_valid5 = 1'b0;
            data_in5  = $urandom;
            lat = 0;
            while (out_valid5 !== 1'b1 && lat < 20) begin
                @(negedge clock);
                lat++;
            end
            n_vec++;
            if (lat != LAT5) begin
                n_err++;
                $display("FAIL lat1_lat[%0d]: latency %0d want %0d", i, lat, LAT5);
            end
            e = (exp5_q.size() > 0) ? exp5_q.pop_front() : 32'hx;
            n_vec++;
            if (data_out5 !== e) begin
                n_err++;
                $display("FAIL lat1_data[%0d]: got %h want %h", i, data_out5, e);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_lat1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
